xy_event_monitor: RTL and testbench
===================================

Name: xy_event_monitor

Overview:
- Downstream consumer of the registered X/Y outputs of the A/B/C/D logic stage.
- Detects rising edges on x and y and keeps a saturating event count for each.
- Runs a small FSM that flags y held high for HOLD or more consecutive cycles.
- Results feed the status/debug readout; all outputs are registered.

Parameters:
- CW, 8: width of each event counter.
- HOLD, 4: consecutive y-high samples needed to assert y_stuck. Legal range is HOLD ≥ 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- x  input  1  X output of upstream stage, already registered in the clk domain.
- y  input  1  Y output of upstream stage, already registered in the clk domain.
- clear  input  1  synchronous counter clear, active-high.
- x_rise  output  1  one-cycle pulse on an x rising edge.
- y_rise  output  1  one-cycle pulse on a y rising edge.
- x_count  output  CW  saturating count of x rising edges.
- y_count  output  CW  saturating count of y rising edges.
- y_stuck  output  1  y has been high for HOLD or more consecutive samples.

Behaviour:
- Single clock domain. All state updates on the clk rising edge. No combinational path from input to output.
- Reset (synchronous, active-high), at the edge where reset=1:
  - x_prev, y_prev ← 0; x_rise, y_rise ← 0.
  - x_count, y_count ← 0; y_stuck ← 0.
  - Run counter ← 0; FSM ← IDLE.
  - Reset has priority over clear and over all input activity. Reset mid-run discards the run; counting restarts from zero.
- Edge detect:
  - At each edge: x_rise ← x & ~x_prev, then x_prev ← x. Same for y.
  - Latency: pulse visible the cycle after the edge that samples the 0→1 transition. Pulse width is exactly one cycle.
  - Because prev resets to 0, an input already high at the first post-reset edge counts as a rise.
- Counters, evaluated per counter each cycle in priority order:
  - reset → 0.
  - clear → 0. clear wins over a coincident rise; the rise pulse is still emitted but not counted.
  - Rise detected and count < 2^CW−1 → count+1.
  - Otherwise hold. At 2^CW−1 the counter saturates, with no wrap.
  - Count updates on the same edge as the rise pulse register.
- Y-hold FSM, with run counter RC of width $clog2(HOLD+1) that saturates at HOLD:
  - IDLE: y=1 → RC←1. Go to STUCK if HOLD==1, else RUN. y=0 → stay in IDLE.
  - RUN: y=1 → RC←RC+1, and go to STUCK when RC+1==HOLD. y=0 → RC←0, IDLE.
  - STUCK: y=1 → stay in STUCK. y=0 → RC←0, IDLE.
  - y_stuck is a registered copy of (next_state==STUCK).
  - y_stuck rises at the edge sampling the HOLD-th consecutive y=1. It falls at the first edge sampling y=0.
  - clear does not affect the FSM.
- x and y are independent. Simultaneous rises on both are each counted in the same cycle.

Decomposition:
- Package xy_event_monitor_pkg holds:
  - state typedef (IDLE, RUN, STUCK, 2-bit encoding);
  - default constants CW_DEF=8 and HOLD_DEF=4.
- Sub-module rise_counter (params CW; ports clk, reset, clear, in, rise, count) contains the prev register, the rise pulse and the saturating counter.
- rise_counter is instantiated twice, once for x and once for y. The FSM stays in the top level.

Test Plan:
1. Reset held 2 cycles with x=y=1, then release, x=y=1 steady → x_rise=y_rise=1 for exactly one cycle; x_count=y_count=1; y_stuck=1 at the 4th sampled-high edge after release; all outputs 0 while reset=1.
2. x toggles 0,1,0,1… for 10 cycles, CW=8 → 5 single-cycle x_rise pulses, x_count=5; y_count=0.
3. CW=3, 9 x rising edges → x_count climbs to 7 and holds 7; no wrap to 0.
4. clear=1 on the same edge as an x rise, with x_count=4 → x_rise=1, x_count=0; next rise gives x_count=1.
5. HOLD=4: y high 3 cycles, low 1, high 5 → y_stuck stays 0 through the first burst; asserts on the 4th high sample of the second burst; deasserts on the first 0 sample.
6. Reset asserted while FSM is in RUN (RC=2), then y held high → run restarts; y_stuck only after 4 fresh high samples post-reset.

Source files
------------

// File: rtl/xy_event_monitor_pkg.sv
// rtl/xy_event_monitor_pkg.sv - shared types and defaults for the X/Y event monitor
package xy_event_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUCK = 2'd2
  } state_t;

  localparam int CW_DEF   = 8;
  localparam int HOLD_DEF = 4;

endpackage

// File: rtl/xy_event_monitor_rise_counter.sv
// rtl/xy_event_monitor_rise_counter.sv - rising-edge pulse plus saturating edge counter
module rise_counter
  import xy_event_monitor_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in,
  output logic          rise,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] COUNT_MAX = '1;

  logic prev;
  logic rise_d;

  assign rise_d = in & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      rise  <= 1'b0;
      count <= '0;
    end else begin
      prev <= in;
      rise <= rise_d;
      // clear still lets the pulse out but drops the coincident rise from the count
      if (clear) begin
        count <= '0;
      end else if (rise_d && (count != COUNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xy_event_monitor.sv
// rtl/xy_event_monitor.sv - edge counters for x/y and a y-held-high detector
module xy_event_monitor
  import xy_event_monitor_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  input  logic          y,
  input  logic          clear,
  output logic          x_rise,
  output logic          y_rise,
  output logic [CW-1:0] x_count,
  output logic [CW-1:0] y_count,
  output logic          y_stuck
);

  localparam int RCW = $clog2(HOLD + 1);
  localparam logic [RCW-1:0] HOLD_RC = RCW'(HOLD);
  localparam logic [RCW-1:0] ONE_RC  = RCW'(1);

  rise_counter #(.CW(CW)) u_x_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .in    (x),
    .rise  (x_rise),
    .count (x_count)
  );

  rise_counter #(.CW(CW)) u_y_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .in    (y),
    .rise  (y_rise),
    .count (y_count)
  );

  state_t         state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rc_q    <= '0;
      y_stuck <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      y_stuck <= (state_d == STUCK);
    end
  end

  // rc stays pinned at HOLD while in STUCK, so it never wraps
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    unique case (state_q)
      IDLE: begin
        if (y) begin
          rc_d    = ONE_RC;
          state_d = (HOLD == 1) ? STUCK : RUN;
        end
      end
      RUN: begin
        if (y) begin
          rc_d = rc_q + 1'b1;
          if ((rc_q + 1'b1) == HOLD_RC) begin
            state_d = STUCK;
          end
        end else begin
          rc_d    = '0;
          state_d = IDLE;
        end
      end
      STUCK: begin
        if (!y) begin
          rc_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        rc_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xy_event_monitor.sv
// tb/tb_xy_event_monitor.sv - scoreboard bench for xy_event_monitor (two parameter sets)
module tb_xy_event_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x = 1'b0;
  logic y = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic       a_x_rise, a_y_rise, a_y_stuck;
  logic [7:0] a_x_count, a_y_count;
  logic       b_x_rise, b_y_rise, b_y_stuck;
  logic [2:0] b_x_count, b_y_count;

  xy_event_monitor #(.CW(8), .HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .x(x), .y(y), .clear(clear),
    .x_rise(a_x_rise), .y_rise(a_y_rise),
    .x_count(a_x_count), .y_count(a_y_count), .y_stuck(a_y_stuck)
  );

  xy_event_monitor #(.CW(3), .HOLD(1)) dut_b (
    .clk(clk), .reset(reset), .x(x), .y(y), .clear(clear),
    .x_rise(b_x_rise), .y_rise(b_y_rise),
    .x_count(b_x_count), .y_count(b_y_count), .y_stuck(b_y_stuck)
  );

  typedef struct {
    bit xr;
    bit yr;
    int xc;
    int yc;
    bit st;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  // reference state: last sampled inputs, counts, and length of current y-high run
  int m_xp[2], m_yp[2], m_xc[2], m_yc[2], m_run[2];
  int m_max[2];
  int m_hold[2];

  task automatic model_step(input int i, input bit r, input bit xv, input bit yv,
                            input bit c, output exp_t e);
    bit xr, yr;
    if (r) begin
      m_xp[i] = 0; m_yp[i] = 0; m_xc[i] = 0; m_yc[i] = 0; m_run[i] = 0;
      xr = 0; yr = 0;
    end else begin
      xr = xv && (m_xp[i] == 0);
      yr = yv && (m_yp[i] == 0);
      m_xp[i] = xv;
      m_yp[i] = yv;
      if (c) m_xc[i] = 0; else if (xr && m_xc[i] < m_max[i]) m_xc[i]++;
      if (c) m_yc[i] = 0; else if (yr && m_yc[i] < m_max[i]) m_yc[i]++;
      m_run[i] = yv ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 0;
    end
    e.xr = xr;
    e.yr = yr;
    e.xc = m_xc[i];
    e.yc = m_yc[i];
    e.st = (m_run[i] >= m_hold[i]);
    e.cyc = cycle_no;
  endtask

  task automatic cyc(input bit r, input bit xv, input bit yv, input bit c);
    exp_t ea, eb;
    @(negedge clk);
    reset = r; x = xv; y = yv; clear = c;
    cycle_no++;
    model_step(0, r, xv, yv, c, ea);
    model_step(1, r, xv, yv, c, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      checks++;
      if (a_x_rise !== e.xr || a_y_rise !== e.yr || a_x_count !== 8'(e.xc) ||
          a_y_count !== 8'(e.yc) || a_y_stuck !== e.st) begin
        failures++;
        $display("FAIL dut_a cycle %0d: got xr=%b yr=%b xc=%0d yc=%0d st=%b, want xr=%b yr=%b xc=%0d yc=%0d st=%b",
                 e.cyc, a_x_rise, a_y_rise, a_x_count, a_y_count, a_y_stuck,
                 e.xr, e.yr, e.xc, e.yc, e.st);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checks++;
      if (b_x_rise !== e.xr || b_y_rise !== e.yr || b_x_count !== 3'(e.xc) ||
          b_y_count !== 3'(e.yc) || b_y_stuck !== e.st) begin
        failures++;
        $display("FAIL dut_b cycle %0d: got xr=%b yr=%b xc=%0d yc=%0d st=%b, want xr=%b yr=%b xc=%0d yc=%0d st=%b",
                 e.cyc, b_x_rise, b_y_rise, b_x_count, b_y_count, b_y_stuck,
                 e.xr, e.yr, e.xc, e.yc, e.st);
      end
    end
  end

  initial begin
    m_max[0] = 255; m_max[1] = 7;
    m_hold[0] = 4;  m_hold[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_xp[i] = 0; m_yp[i] = 0; m_xc[i] = 0; m_yc[i] = 0; m_run[i] = 0;
    end

    // reset held with inputs high, then steady high after release
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0);

    // x toggling, y low; then enough extra rises to saturate the 3-bit counter
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, k[0], 0, 0);
    for (int k = 0; k < 18; k++) cyc(0, k[0], 0, 0);

    // clear coincident with a rise at count 4, then one more rise
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, k[0], 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);

    // y bursts: 3 high, 1 low, 5 high, low
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // reset in the middle of a y run, then a fresh run
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0);

    // randomized traffic with occasional clear/reset, biased toward long y runs
    for (int k = 0; k < 600; k++) begin
      bit r, c, xv, yv;
      r  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 19) == 0);
      xv = $urandom_range(0, 1);
      yv = ($urandom_range(0, 9) < 7);
      cyc(r, xv, yv, c);
    end

    // long x toggle stretch with no reset so the 8-bit counter saturates too
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 540; k++) cyc(0, k[0], 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending a=%0d b=%0d, want 0 0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
